ldpc_encode: RTL and testbench

- Combinational-core, registered-output binary linear block encoder for the LDPC datapath.
- Computes codeword = info_bits × G over GF(2). G is a K×N generator matrix supplied flattened on a port, so one netlist serves any code loaded at run time.
- Sits between the info-bit source and the channel/modulator; the top level feeds it a generator loaded from memory.

---
 rtl/ldpc_encode.sv | 130 +++++++++++++
 tb/tb_ldpc_encode.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_encode.sv
// ============================================================================
// Module   : ldpc_encode
// Brief    : GF(2) block encoder, codeword = info_bits x G, with G on a port.
//            Define LDPC_ENC_SERIAL_EN for the row-serial variant with o_busy.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ldpc_encode #(
  parameter int N = 11,
  parameter int K = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [K-1:0]     info_bits,
  input  logic [K*N-1:0]   generator_p,
  output logic [N-1:0]     codeword,
`ifdef LDPC_ENC_SERIAL_EN
  output logic             o_busy,
`endif
  output logic             o_valid
);

`ifdef LDPC_ENC_SERIAL_EN

  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(K - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [RW-1:0]     row_cnt, row_cnt_n;
  logic [N-1:0]      acc, acc_n;
  logic [K-1:0]      info_q, info_n;
  logic [K*N-1:0]    gen_q, gen_n;
  logic [N-1:0]      cw_n;
  logic              valid_n;

  // Operands are shifted each BUSY cycle so the current row is always at the top.
  always_comb begin
    state_n   = state;
    row_cnt_n = row_cnt;
    acc_n     = acc;
    info_n    = info_q;
    gen_n     = gen_q;
    cw_n      = codeword;
    valid_n   = 1'b0;
    case (state)
      IDLE: begin
        if (i_en) begin
          info_n    = info_bits;
          gen_n     = generator_p;
          acc_n     = '0;
          row_cnt_n = '0;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        acc_n     = acc ^ ({N{info_q[K-1]}} & gen_q[K*N-1 -: N]);
        info_n    = info_q << 1;
        gen_n     = gen_q << N;
        row_cnt_n = row_cnt + 1'b1;
        if (row_cnt == LAST_ROW) begin
          cw_n    = acc_n;
          valid_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      acc      <= '0;
      info_q   <= '0;
      gen_q    <= '0;
      codeword <= '0;
      o_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      row_cnt  <= row_cnt_n;
      acc      <= acc_n;
      info_q   <= info_n;
      gen_q    <= gen_n;
      codeword <= cw_n;
      o_valid  <= valid_n;
    end
  end

  assign o_busy = (state == BUSY);

`else

  logic [N-1:0] product;

  // One AND/XOR-reduce tree per column; column c lands on bit N-1-c.
  generate
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [K-1:0] terms;
      for (genvar r = 0; r < K; r++) begin : g_row
        assign terms[r] = info_bits[K-1-r] & generator_p[(K-r)*N-1-c];
      end
      assign product[N-1-c] = ^terms;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      codeword <= '0;
      o_valid  <= 1'b0;
    end else if (i_en) begin
      codeword <= product;
      o_valid  <= 1'b1;
    end else begin
      o_valid  <= 1'b0;
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_ldpc_encode.sv
// ============================================================================
// Module   : tb_ldpc_encode
// Brief    : Self-checking bench for ldpc_encode (parallel or serial build).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ldpc_encode;

  localparam int N = 11;
  localparam int K = 6;

  // Systematic [I6 | P] generator used by the directed vectors.
  localparam logic [K*N-1:0] G_SYS = {
    6'b100000, 5'b11000,
    6'b010000, 5'b01100,
    6'b001000, 5'b00110,
    6'b000100, 5'b00011,
    6'b000010, 5'b10001,
    6'b000001, 5'b11111
  };

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_en = 1'b0;
  logic [K-1:0]   info_bits = '0;
  logic [K*N-1:0] generator_p = G_SYS;
  logic [N-1:0]   codeword;
  logic           o_valid;
`ifdef LDPC_ENC_SERIAL_EN
  logic           o_busy;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  ldpc_encode #(.N(N), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .info_bits  (info_bits),
    .generator_p(generator_p),
    .codeword   (codeword),
`ifdef LDPC_ENC_SERIAL_EN
    .o_busy     (o_busy),
`endif
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  // Direct reading of the arithmetic rule: column c = XOR_r info[K-1-r] & G[r][c].
  function automatic logic [N-1:0] encode(input logic [K-1:0] info, input logic [K*N-1:0] g);
    logic [N-1:0] cw;
    cw = '0;
    for (int c = 0; c < N; c++) begin
      logic b;
      b = 1'b0;
      for (int r = 0; r < K; r++) b = b ^ (info[K-1-r] & g[(K-r)*N-1-c]);
      cw[N-1-c] = b;
    end
    return cw;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] exp_cw = '0;
  logic         exp_valid = 1'b0;
`ifdef LDPC_ENC_SERIAL_EN
  logic         m_busy = 1'b0;
  int           m_left = 0;
  logic [N-1:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_left    <= 0;
      exp_cw    <= '0;
      exp_valid <= 1'b0;
    end else if (!m_busy) begin
      exp_valid <= 1'b0;
      if (i_en) begin
        m_pend <= encode(info_bits, generator_p);
        m_left <= K;
        m_busy <= 1'b1;
      end
    end else begin
      if (m_left == 1) begin
        exp_cw    <= m_pend;
        exp_valid <= 1'b1;
        m_busy    <= 1'b0;
      end
      m_left <= m_left - 1;
    end
  end
`else
  always @(posedge clk) begin
    if (rst) begin
      exp_cw    <= '0;
      exp_valid <= 1'b0;
    end else if (i_en) begin
      exp_cw    <= encode(info_bits, generator_p);
      exp_valid <= 1'b1;
    end else begin
      exp_valid <= 1'b0;
    end
  end
`endif

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_codeword", codeword, exp_cw);
      chk("model_valid", N'(o_valid), N'(exp_valid));
`ifdef LDPC_ENC_SERIAL_EN
      chk("model_busy", N'(o_busy), N'(m_busy));
`endif
    end
  end

  // Launch one encode and wait (bounded) for the valid strobe, then check a literal.
  task automatic run_vec(input string name, input logic [K-1:0] info, input logic [N-1:0] exp);
    bit found;
    info_bits = info;
    i_en = 1'b1;
    step();
    i_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < K + 3 && !found; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) found = 1'b1;
    end
    chk({name, "_valid_seen"}, N'(found), N'(1'b1));
    chk(name, codeword, exp);
  endtask

  initial begin
    logic [95:0] rnd;

    // Reset held two clocks with encode requested.
    rst = 1'b1; i_en = 1'b1; info_bits = 6'b111111; generator_p = G_SYS;
    step();
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_cw_1", codeword, 11'b00000000000);
    chk("reset_valid_1", N'(o_valid), N'(1'b0));
    step();
    @(negedge clk);
    chk("reset_cw_2", codeword, 11'b00000000000);
    chk("reset_valid_2", N'(o_valid), N'(1'b0));
    rst = 1'b0; i_en = 1'b0;
    step();

    run_vec("all_ones", 6'b111111, 11'b11111111111);
    run_vec("single_row", 6'b100000, 11'b10000011000);
    run_vec("all_zero", 6'b000000, 11'b00000000000);
    run_vec("mixed", 6'b101010, 11'b10101001111);

    // Hold: inputs move while i_en is low.
    info_bits = 6'b111111;
    repeat (3) step();
    @(negedge clk);
    chk("hold_cw", codeword, 11'b10101001111);
    chk("hold_valid", N'(o_valid), N'(1'b0));

`ifdef LDPC_ENC_SERIAL_EN
    // Re-asserting i_en during BUSY must not disturb latched operands.
    step();
    info_bits = 6'b100000; i_en = 1'b1;
    step();
    info_bits = 6'b111111;
    repeat (3) step();
    i_en = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < K + 3 && !found; i++) begin
        @(negedge clk);
        if (o_valid === 1'b1) found = 1'b1;
      end
      chk("busy_ignore_valid_seen", N'(found), N'(1'b1));
      chk("busy_ignore_cw", codeword, 11'b10000011000);
    end

    // Reset in the middle of BUSY aborts without a pulse.
    step();
    info_bits = 6'b111111; i_en = 1'b1;
    step();
    i_en = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", N'(o_busy), N'(1'b0));
    chk("abort_cw", codeword, 11'b00000000000);
    begin
      bit pulsed;
      pulsed = 1'b0;
      for (int i = 0; i < K + 2; i++) begin
        @(negedge clk);
        if (o_valid !== 1'b0) pulsed = 1'b1;
      end
      chk("abort_no_pulse", N'(pulsed), N'(1'b0));
    end
`endif

    // Randomized traffic with occasional resets and generator reloads.
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      rst = ($urandom_range(0, 59) == 0);
      i_en = ($urandom_range(0, 3) != 0);
      info_bits = ($urandom_range(0, 9) == 0) ? '0 : K'($urandom_range(0, (1 << K) - 1));
      if ($urandom_range(0, 3) == 0) begin
        rnd = {$urandom(), $urandom(), $urandom()};
        generator_p = rnd[K*N-1:0];
      end
    end
    step();
    rst = 1'b0; i_en = 1'b0;
    repeat (K + 3) step();
    cmp_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
